// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN) mid-bit sampling into a small FWFT FIFO.
// Optional feature macro: UART_RX_PARITY_EN enables the even-parity bit and parity_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_C = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4, S_WAIT_HIGH = 3'd5
  } state_t;

  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4, S_WAIT_HIGH = 3'd5
  } state_t;
`endif

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_sync;
  logic            r_rxs_d;
  logic            w_rxs;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit_cnt, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            w_push, w_ferr, w_perr;
  logic            r_frame_err, r_overrun;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bit, w_par_nxt;
  logic            r_parity_err;
`endif

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr, r_rd_ptr;
  logic            w_full, w_empty, w_pop, w_wr_en;

  assign w_rxs = r_sync[1];

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], urx};
      r_rxs_d <= w_rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter restarts at 1 on every sample so the next sample lands one full bit later
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    w_perr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par_bit;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_rxs_d && !w_rxs) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = ONE_C;
          w_bit_nxt   = 3'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt == HALF_C) begin
          w_cnt_nxt   = ONE_C;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + ONE_C;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_C) begin
          w_cnt_nxt   = ONE_C;
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_bit_nxt   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE_C;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == FULL_C) begin
          w_cnt_nxt   = ONE_C;
          w_par_nxt   = w_rxs;
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + ONE_C;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == FULL_C) begin
          w_cnt_nxt = ONE_C;
          if (!w_rxs) begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (!even_parity_ok(r_shift, r_par_bit)) begin
            w_perr      = 1'b1;
            w_state_nxt = S_IDLE;
`endif
          end else begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE_C;
        end
      end
      S_WAIT_HIGH: begin
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
`endif
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= w_par_nxt;
`endif
    end
  end

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = rx_ready && !w_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted
  assign w_wr_en  = w_push && (!w_full || w_pop);
  assign rx_valid = !w_empty;
  assign rx_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_push && w_full && !w_pop;
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_perr;
    end
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the `risc_v` core's `urx` pin, the counterpart of the core's UART transmitter on `utx`. It deserialises 8N1 frames, or 8E1 when parity is compiled in, by sampling at mid-bit. Received bytes are buffered in a small first-word-fall-through FIFO, and the core's load/store unit drains that FIFO through a valid/ready handshake. Framing, parity and overrun errors are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit (100 MHz / 115200); must be ≥ 4; benches use 16.
- `FIFO_DEPTH`, 4, receive buffer entries; must be a power of 2 and ≥ 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `urx`  in  1  serial line input; idle high; asynchronous to `clk`.
- `rx_data`  out  8  FIFO head byte; meaningful only while `rx_valid` = 1.
- `rx_valid`  out  1  FIFO is not empty.
- `rx_ready`  in  1  consumer pops the head byte on a cycle where `rx_valid & rx_ready` = 1.
- `frame_err`  out  1  one-cycle pulse: stop bit was sampled as 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied to 0 when parity is not compiled in.
- `overrun`  out  1  one-cycle pulse: a good byte arrived while the FIFO was full.

## Operation
- `urx` passes through a 2-flop synchroniser, reset value 1. All logic below uses the synchronised line `rxs`.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
  - IDLE → START when `rxs` shows a 1→0 transition. The bit counter is cleared.
  - START: wait `CLKS_PER_BIT/2` cycles, then sample. If `rxs` = 1 it was a glitch: return to IDLE with no flags. If `rxs` = 0, go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles. Bits arrive LSB first into a shift register. After 8 samples, go to PARITY if compiled in, otherwise to STOP.
  - PARITY: sample once after `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: sample once after `CLKS_PER_BIT` cycles.
    - `rxs` = 1 and parity OK: push the byte and go to IDLE.
    - `rxs` = 1 and parity bad: pulse `parity_err`, drop the byte, go to IDLE.
    - `rxs` = 0: pulse `frame_err`, drop the byte, go to WAIT_HIGH.
  - WAIT_HIGH → IDLE once `rxs` = 1. This stops a break condition from being read as back-to-back start bits.
- Each sample takes the single value of `rxs` on the sample cycle. There is no majority voting.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than the index, so full and empty are distinguished.
  - `rx_data` = `mem[rd_ptr]` (first-word fall-through).
  - A push while full is dropped and pulses `overrun`. FIFO contents are unchanged.
  - A push while full in the same cycle as a pop: the pop frees a slot, so the push is accepted and `overrun` stays 0.
  - A push while empty: the new byte appears at `rx_data` with `rx_valid` = 1 on the next cycle.
  - A pop while empty has no effect.

## Timing
- Reset values: FSM = IDLE, pointers = 0, `rx_valid` = 0, `rx_data` = 0, `frame_err` = `parity_err` = `overrun` = 0, synchroniser flops = 1.
- Reset asserted mid-frame discards the partial byte and all FIFO contents. After release, the receiver waits in IDLE for a fresh 1→0 edge on `rxs`.
- Latency, measured from the `urx` falling edge (cycle 0), with counters counting from the cycle of edge detection:
  - The edge appears on `rxs` at cycle 2.
  - Start sample: cycle 2 + `CLKS_PER_BIT/2`.
  - Stop sample: cycle 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`, plus 1·`CLKS_PER_BIT` more with parity.
  - `rx_valid`, `frame_err`, `parity_err` and `overrun` become visible one cycle after the stop sample.
  - For `CLKS_PER_BIT` = 16 without parity: stop sample at cycle 154, outputs visible at cycle 155.
- A new start edge is accepted on the cycle after the STOP → IDLE transition. A stop bit of exactly one bit time therefore allows full line rate.
- Error pulses are exactly one cycle wide. At most one error flag pulses per frame.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: the frame has an even-parity bit after bit 7. The PARITY state exists. Even parity means the XOR of the 8 data bits and the parity bit must be 0. `parity_err` is live.
  - Undefined: PARITY state and parity logic are removed. Frames are 8N1. `parity_err` is a constant 0.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16 and `FIFO_DEPTH` = 4.
- Send 0xA5 (8N1) with `rx_ready` = 0 → `rx_valid` rises at cycle 155, `rx_data` = 0xA5. Assert `rx_ready` for 1 cycle → `rx_valid` = 0 on the next cycle.
- Drive `urx` low for 4 cycles, then high → no `rx_valid`, no error pulse, FSM back in IDLE.
- Send 0x3C with stop bit = 0 → `frame_err` pulses once at cycle 155, FIFO stays empty. Hold `urx` low 100 more cycles → no further bytes and no further pulses.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with `rx_ready` = 0 → `overrun` pulses on the 5th byte only. Draining yields 0x01–0x04 in order, then `rx_valid` = 0.
- With the FIFO full, hold `rx_ready` = 1 on the cycle the 5th stop bit is accepted → no `overrun`. Drain order is 0x02, 0x03, 0x04, 0x05.
- Assert `rst_n` = 0 at bit 4 of 0x77, release it, then send 0x11 → only 0x11 is received.
- With `UART_RX_PARITY_EN` defined, send 0x07 with parity bit 0 → `parity_err` pulses at cycle 171, no byte is pushed. With parity bit 1 → 0x07 is received.
